// File: rtl/block_quantizer.sv
// ---------------------------------------------------------------------------
// block_quantizer
//
// Collects one 8x8 block of signed transform coefficients in raster order,
// quantizes each one as it arrives with a position-dependent rounding right
// shift and saturation, and then drains the stored block to the downstream
// side. Quantization is coarser further from the DC term.
//
// Build option:
//   ZIGZAG_EN  when defined, the block is drained in JPEG zigzag order;
//              otherwise it is drained in raster order.
//
// Parameters:
//   DATA_W     width of the signed input coefficient
//   OUT_W      width of the signed quantized output coefficient
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_data is presented this cycle
//   in_ready   block accepts in_data this cycle (high while loading)
//   in_data    signed coefficient, raster order (row-major)
//   out_valid  out_data is valid (high while draining)
//   out_ready  downstream accepts out_data this cycle
//   out_data   signed quantized coefficient
//   out_index  raster index (row*8+col) of the coefficient on out_data
//   out_last   marks the 64th output of a block
// ---------------------------------------------------------------------------
module block_quantizer #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [5:0]               out_index,
    output logic                     out_last
);

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Saturation bounds, held at the width of the rounded sum so the
    // comparisons below are plain signed compares.
    localparam logic signed [DATA_W:0] Q_MAX = (DATA_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [DATA_W:0] Q_MIN = ~Q_MAX;

`ifdef ZIGZAG_EN
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
`endif

    state_t                    state;
    state_t                    state_next;
    logic [5:0]                k;
    logic [5:0]                j;
    logic [5:0]                rd_index;
    logic                      load_fire;
    logic                      drain_fire;
    logic signed [OUT_W-1:0]   buffer [64];

    logic [3:0]                diag;
    logic [3:0]                shift;
    logic signed [DATA_W:0]    rounding;
    logic signed [DATA_W:0]    summed;
    logic signed [DATA_W:0]    shifted;
    logic signed [OUT_W-1:0]   q;

    assign load_fire  = (state == LOAD)  && in_valid;
    assign drain_fire = (state == DRAIN) && out_ready;

    // Quantize the sample arriving at position k. The sum is one bit wider
    // than the input so adding the rounding constant cannot overflow.
    always_comb begin
        diag     = {1'b0, k[5:3]} + {1'b0, k[2:0]};
        shift    = 4'd1 + {1'b0, diag[3:1]};
        rounding = (DATA_W+1)'(1) << (shift - 4'd1);
        summed   = {in_data[DATA_W-1], in_data} + rounding;
        shifted  = summed >>> shift;
        if (shifted > Q_MAX) begin
            q = Q_MAX[OUT_W-1:0];
        end else if (shifted < Q_MIN) begin
            q = Q_MIN[OUT_W-1:0];
        end else begin
            q = shifted[OUT_W-1:0];
        end
    end

    // Next-state and handshake outputs. Transitions use the raw valid/ready
    // inputs; the state already gates which side is allowed to transfer.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (k == 6'd63)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (j == 6'd63)) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // State and counters. Both counters wrap to zero after the 64th
    // transfer, which is exactly where the next block or drain starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            k     <= '0;
            j     <= '0;
        end else begin
            state <= state_next;
            if (load_fire) begin
                k <= k + 6'd1;
            end
            if (drain_fire) begin
                j <= j + 6'd1;
            end
        end
    end

    // Coefficient store; a reset simply abandons whatever it holds.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            buffer[k] <= q;
        end
    end

`ifdef ZIGZAG_EN
    assign rd_index = ZIGZAG[j];
`else
    assign rd_index = j;
`endif

    // Outputs read straight from the store, so they stay put while the
    // downstream side stalls and read as zero whenever nothing is draining.
    always_comb begin
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (state == DRAIN) begin
            out_data  = buffer[rd_index];
            out_index = rd_index;
            out_last  = (j == 6'd63);
        end
    end

endmodule
